// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_mp
// Description : Multi-port architectural register file with a per-register
//               busy scoreboard. NRD combinational read ports, NWR write
//               ports, optional same-cycle write-to-read bypass, x0 tied to 0.
// Revision    : 1.0 - initial release for the dual-issue pipeline
// ============================================================================
module reg_file_mp #(
    parameter int DWIDTH = 64,
    parameter int NREGS  = 32,
    parameter int NRD    = 4,
    parameter int NWR    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NRD*AW-1:0]     rd_idx,
    output logic [NRD*DWIDTH-1:0] rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic [NWR-1:0]        wr_en,
    input  logic [NWR*AW-1:0]     wr_idx,
    input  logic [NWR*DWIDTH-1:0] wr_data,
    input  logic [NWR-1:0]        alloc_en,
    input  logic [NWR*AW-1:0]     alloc_idx,
    input  logic                  flush
);

    localparam logic [AW-1:0] c_ZERO_IDX = '0;

    // Architectural state: one flop row per register plus one busy bit each.
    logic [DWIDTH-1:0] r_regs [NREGS];
    logic [NREGS-1:0]  r_busy;

    // Per-register decode of this cycle's write and allocation traffic.
    logic [NREGS-1:0]  w_wr_hit;
    logic [DWIDTH-1:0] w_wr_val [NREGS];
    logic [NREGS-1:0]  w_alloc_hit;
    logic [NREGS-1:0]  w_busy_nxt;

    // Decode write/alloc ports per register; ascending port order lets the
    // highest-numbered writer overwrite earlier ones. x0 is never a target.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            w_wr_hit[r]    = 1'b0;
            w_wr_val[r]    = '0;
            w_alloc_hit[r] = 1'b0;
        end
        for (int r = 1; r < NREGS; r++) begin
            for (int w = 0; w < NWR; w++) begin
                if (wr_en[w] && (wr_idx[w*AW +: AW] == AW'(r))) begin
                    w_wr_hit[r] = 1'b1;
                    w_wr_val[r] = wr_data[w*DWIDTH +: DWIDTH];
                end
                if (alloc_en[w] && (alloc_idx[w*AW +: AW] == AW'(r))) begin
                    w_alloc_hit[r] = 1'b1;
                end
            end
        end
    end

    // Scoreboard next state: flush clears everything; otherwise a new
    // allocation beats a completing write to the same register.
    always_comb begin
        w_busy_nxt = r_busy;
        if (flush) begin
            w_busy_nxt = '0;
        end else begin
            w_busy_nxt = (r_busy & ~w_wr_hit) | w_alloc_hit;
        end
    end

    // Commit writes and scoreboard updates on the rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                r_regs[r] <= '0;
            end
            r_busy <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (w_wr_hit[r]) begin
                    r_regs[r] <= w_wr_val[r];
                end
            end
            r_busy <= w_busy_nxt;
        end
    end

    // Combinational read ports with optional same-cycle write bypass.
    generate
        for (genvar p = 0; p < NRD; p++) begin : g_rd
            logic [AW-1:0] w_idx;
            logic          w_byp;

            assign w_idx = rd_idx[p*AW +: AW];
            assign w_byp = (BYPASS != 0) && w_wr_hit[w_idx];

            assign rd_data[p*DWIDTH +: DWIDTH] = (w_idx == c_ZERO_IDX) ? '0 :
                                                 w_byp ? w_wr_val[w_idx] :
                                                 r_regs[w_idx];
            assign rd_busy[p] = (w_idx != c_ZERO_IDX) && r_busy[w_idx] && !w_byp;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_mp
// Description : Self-checking bench for reg_file_mp: directed scenarios plus
//               randomized traffic against a behavioural register-file model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_mp;

    localparam int DW  = 64;
    localparam int NR  = 32;
    localparam int NRD = 4;
    localparam int NWR = 2;
    localparam int BYP = 1;
    localparam int AW  = 5;

    logic                clk = 1'b0;
    logic                reset;
    logic [NRD*AW-1:0]   rd_idx;
    logic [NRD*DW-1:0]   rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_idx;
    logic [NWR*DW-1:0]   wr_data;
    logic [NWR-1:0]      alloc_en;
    logic [NWR*AW-1:0]   alloc_idx;
    logic                flush;

    reg_file_mp #(
        .DWIDTH (DW),
        .NREGS  (NR),
        .NRD    (NRD),
        .NWR    (NWR),
        .BYPASS (BYP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_data   (wr_data),
        .alloc_en  (alloc_en),
        .alloc_idx (alloc_idx),
        .flush     (flush)
    );

    always #5 clk = ~clk;

    // Reference model: plain arrays of register values and busy flags.
    logic [DW-1:0] m_regs [NR];
    bit            m_busy [NR];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit wr_hits(input int idx);
        bit hit = 1'b0;
        for (int w = 0; w < NWR; w++) begin
            if (wr_en[w] && int'(wr_idx[w*AW +: AW]) == idx) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic [DW-1:0] exp_data(input int idx);
        if (idx == 0) return '0;
        for (int w = NWR - 1; w >= 0; w--) begin
            if (BYP != 0 && wr_en[w] && int'(wr_idx[w*AW +: AW]) == idx)
                return wr_data[w*DW +: DW];
        end
        return m_regs[idx];
    endfunction

    function automatic bit exp_busy(input int idx);
        if (idx == 0) return 1'b0;
        if (BYP != 0 && wr_hits(idx)) return 1'b0;
        return m_busy[idx];
    endfunction

    task automatic check_all(input string tag);
        for (int p = 0; p < NRD; p++) begin
            int idx;
            idx = int'(rd_idx[p*AW +: AW]);
            chk($sformatf("%s.data%0d", tag, p), rd_data[p*DW +: DW], exp_data(idx));
            chk($sformatf("%s.busy%0d", tag, p), {63'b0, rd_busy[p]}, {63'b0, exp_busy(idx)});
        end
    endtask

    // Apply the currently driven inputs to the model, as the edge would.
    task automatic model_edge();
        if (reset) begin
            for (int r = 0; r < NR; r++) begin
                m_regs[r] = '0;
                m_busy[r] = 1'b0;
            end
        end else begin
            for (int w = 0; w < NWR; w++) begin
                int idx;
                idx = int'(wr_idx[w*AW +: AW]);
                if (wr_en[w] && idx != 0) m_regs[idx] = wr_data[w*DW +: DW];
            end
            if (flush) begin
                for (int r = 0; r < NR; r++) m_busy[r] = 1'b0;
            end else begin
                for (int w = 0; w < NWR; w++) begin
                    if (wr_en[w]) m_busy[int'(wr_idx[w*AW +: AW])] = 1'b0;
                end
                for (int a = 0; a < NWR; a++) begin
                    int idx;
                    idx = int'(alloc_idx[a*AW +: AW]);
                    if (alloc_en[a] && idx != 0) m_busy[idx] = 1'b1;
                end
            end
        end
    endtask

    task automatic idle();
        reset     = 1'b0;
        flush     = 1'b0;
        wr_en     = '0;
        wr_idx    = '0;
        wr_data   = '0;
        alloc_en  = '0;
        alloc_idx = '0;
    endtask

    // One cycle: check outputs before the edge, advance model, clear inputs.
    task automatic step(input string tag);
        #2;
        check_all(tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        idle();
    endtask

    task automatic set_wr(input int w, input int idx, input logic [DW-1:0] d);
        wr_en[w]            = 1'b1;
        wr_idx[w*AW +: AW]  = AW'(idx);
        wr_data[w*DW +: DW] = d;
    endtask

    task automatic set_alloc(input int a, input int idx);
        alloc_en[a]           = 1'b1;
        alloc_idx[a*AW +: AW] = AW'(idx);
    endtask

    task automatic set_rd(input int p, input int idx);
        rd_idx[p*AW +: AW] = AW'(idx);
    endtask

    function automatic int rand_idx();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, NR - 1));
        return int'($urandom_range(0, 7));
    endfunction

    initial begin
        idle();
        rd_idx = '0;
        reset  = 1'b1;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        idle();

        // Reset after random writes/allocs clears data and busy everywhere.
        for (int i = 0; i < 6; i++) begin
            set_wr(0, int'($urandom_range(1, 7)), {$urandom, $urandom} | 64'h1);
            set_wr(1, int'($urandom_range(1, 7)), {$urandom, $urandom} | 64'h1);
            set_alloc(0, int'($urandom_range(1, 7)));
            step("t1_fill");
        end
        step("t1_gap0");
        step("t1_gap1");
        reset = 1'b1;
        step("t1_rst");
        for (int p = 0; p < NRD; p++) set_rd(p, p + 1);
        #1;
        for (int p = 0; p < NRD; p++) begin
            chk($sformatf("t1_rst_data%0d", p), rd_data[p*DW +: DW], 64'h0);
            chk($sformatf("t1_rst_busy%0d", p), {63'b0, rd_busy[p]}, 64'h0);
        end

        // Two ports write x5 in one cycle: port 1 wins.
        set_wr(0, 5, 64'hA5A5);
        set_wr(1, 5, 64'h1234);
        step("t2_wr");
        set_rd(0, 5);
        #1 chk("t2_x5", rd_data[0 +: DW], 64'h1234);
        step("t2_rd");

        // Same-cycle bypass of a write to x7.
        set_rd(0, 7);
        set_wr(0, 7, 64'hDEAD);
        #1 chk("t3_bypass", rd_data[0 +: DW], 64'hDEAD);
        step("t3_wr");
        #1 chk("t3_after", rd_data[0 +: DW], 64'hDEAD);
        step("t3_rd");

        // Allocate x9, then retire it with a write.
        set_rd(1, 9);
        set_alloc(0, 9);
        #1 chk("t4_alloc_cycle_busy", {63'b0, rd_busy[1]}, 64'h0);
        step("t4_alloc");
        #1 chk("t4_busy", {63'b0, rd_busy[1]}, 64'h1);
        set_wr(1, 9, 64'h42);
        #1 chk("t4_wr_busy", {63'b0, rd_busy[1]}, 64'h0);
        chk("t4_wr_data", rd_data[1*DW +: DW], 64'h42);
        step("t4_wr");
        #1 chk("t4_done_busy", {63'b0, rd_busy[1]}, 64'h0);
        chk("t4_done_data", rd_data[1*DW +: DW], 64'h42);

        // Alloc and write x3 together: data lands, new producer keeps it busy.
        set_rd(2, 3);
        set_alloc(1, 3);
        set_wr(0, 3, 64'h77);
        step("t5_both");
        #1 chk("t5_busy", {63'b0, rd_busy[2]}, 64'h1);
        chk("t5_data", rd_data[2*DW +: DW], 64'h77);
        flush = 1'b1;
        step("t5_flush");
        #1 chk("t5_flush_busy", {63'b0, rd_busy[2]}, 64'h0);
        chk("t5_flush_data", rd_data[2*DW +: DW], 64'h77);

        // x0 ignores writes and allocs on every port.
        for (int p = 0; p < NRD; p++) set_rd(p, 0);
        for (int w = 0; w < NWR; w++) begin
            set_wr(w, 0, 64'hFFFF);
            set_alloc(w, 0);
        end
        #1;
        for (int p = 0; p < NRD; p++) begin
            chk($sformatf("t6_same_data%0d", p), rd_data[p*DW +: DW], 64'h0);
            chk($sformatf("t6_same_busy%0d", p), {63'b0, rd_busy[p]}, 64'h0);
        end
        step("t6_wr");
        #1;
        for (int p = 0; p < NRD; p++) begin
            chk($sformatf("t6_next_data%0d", p), rd_data[p*DW +: DW], 64'h0);
            chk($sformatf("t6_next_busy%0d", p), {63'b0, rd_busy[p]}, 64'h0);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            for (int p = 0; p < NRD; p++) set_rd(p, rand_idx());
            for (int w = 0; w < NWR; w++) begin
                if ($urandom_range(0, 1) == 1) set_wr(w, rand_idx(), {$urandom, $urandom});
                if ($urandom_range(0, 2) == 0) set_alloc(w, rand_idx());
            end
            flush = ($urandom_range(0, 19) == 0);
            reset = ($urandom_range(0, 199) == 0);
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
